low_freq_gen: RTL and testbench

- Frequency-to-waveform generator: accepts a 4-digit BCD frequency in Hz (0000–9999) and produces a 50%-duty square wave of that frequency.
- Inverse of the measurement path (signal → period → frequency → BCD), so the same board can loop a generated tone back into the frequency meter.
- Internal master FSM sequences three steps: BCD-to-binary conversion, half-period division, then continuous waveform generation.

---
 rtl/low_freq_gen_pkg.sv | 29 ++
 rtl/low_freq_gen_bcd2bin_seq.sv | 54 +++++
 rtl/low_freq_gen.sv | 168 ++++++++++++++++
 tb/tb_low_freq_gen.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/low_freq_gen_pkg.sv
// Shared definitions for the low-frequency square-wave generator:
// master FSM encoding, BCD limits and the default clock rate.
package low_freq_gen_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_CONV = 3'd1;
    localparam logic [2:0] ST_DIV  = 3'd2;
    localparam logic [2:0] ST_LOAD = 3'd3;
    localparam logic [2:0] ST_RUN  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE = ST_IDLE,
        S_CONV = ST_CONV,
        S_DIV  = ST_DIV,
        S_LOAD = ST_LOAD,
        S_RUN  = ST_RUN
    } state_t;

    localparam logic [3:0] BCD_MAX        = 4'd9;
    localparam int         DEFAULT_CLK_HZ = 50_000_000;
    localparam int         NUM_DIGITS     = 4;
    // 9999 needs 14 bits
    localparam int         ACC_W          = 14;

    function automatic logic digit_valid(input logic [3:0] d);
        return (d <= BCD_MAX);
    endfunction

endpackage

// File: rtl/low_freq_gen_bcd2bin_seq.sv
// Sequential 4-digit BCD to binary converter, one digit per clock, MSD first.
// done_tick/invalid flag the cycle whose edge commits the final step.
module bcd2bin_seq
    import low_freq_gen_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       bcd3,
    input  logic [3:0]       bcd2,
    input  logic [3:0]       bcd1,
    input  logic [3:0]       bcd0,
    output logic             done_tick,
    output logic             invalid,
    output logic [ACC_W-1:0] bin
);

    logic [NUM_DIGITS-1:0][3:0] digits_reg;
    logic [1:0]                 idx_reg;
    logic                       busy_reg;
    logic [ACC_W-1:0]           acc_reg;

    logic [3:0]                 digit_cur;
    logic [ACC_W-1:0]           acc_next;

    // idx counts down so digits_reg[3] (bcd3) is consumed first
    assign digit_cur = digits_reg[idx_reg];
    assign acc_next  = acc_reg * ACC_W'(10) + ACC_W'(digit_cur);
    assign invalid   = busy_reg && !digit_valid(digit_cur);
    assign done_tick = busy_reg && digit_valid(digit_cur) && (idx_reg == 2'd0);
    assign bin       = acc_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digits_reg <= '0;
            idx_reg    <= 2'd0;
            busy_reg   <= 1'b0;
            acc_reg    <= '0;
        end else if (start) begin
            digits_reg <= {bcd3, bcd2, bcd1, bcd0};
            idx_reg    <= 2'(NUM_DIGITS - 1);
            busy_reg   <= 1'b1;
            acc_reg    <= '0;
        end else if (busy_reg) begin
            acc_reg <= acc_next;
            if (invalid || done_tick) begin
                busy_reg <= 1'b0;
            end else begin
                idx_reg <= idx_reg - 2'd1;
            end
        end
    end

endmodule

// File: rtl/low_freq_gen.sv
// BCD frequency in, 50% duty square wave out: BCD->binary, half-period
// division of CLK_HZ/2 by the frequency, then a free-running toggle counter.
module low_freq_gen
    import low_freq_gen_pkg::*;
#(
    parameter int CLK_HZ = DEFAULT_CLK_HZ,
    parameter int W      = 26
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic [3:0] bcd3,
    input  logic [3:0] bcd2,
    input  logic [3:0] bcd1,
    input  logic [3:0] bcd0,
    output logic       sq_out,
    output logic       ready,
    output logic       done_tick,
    output logic       err
);

    // remainder/divisor must hold any 14-bit frequency even when W is small
    localparam int             DW       = (W > ACC_W) ? W : ACC_W;
    localparam int             CW       = $clog2(W + 1);
    localparam logic [W-1:0]   HALF_CLK = W'(CLK_HZ / 2);

    state_t           state_reg;
    logic [W-1:0]     quo_reg;
    logic [DW-1:0]    rem_reg;
    logic [DW-1:0]    divisor_reg;
    logic [CW-1:0]    bit_cnt_reg;
    logic [W-1:0]     half_reg;
    logic [W-1:0]     count_reg;
    logic             sq_reg;
    logic             ready_reg;
    logic             done_reg;
    logic             err_reg;

    logic             accept;
    logic             conv_done;
    logic             conv_invalid;
    logic [ACC_W-1:0] conv_bin;

    logic [DW:0]      rem_shift;
    logic             rem_ge;
    logic [DW-1:0]    rem_diff;

    assign accept = start && ready_reg;

    bcd2bin_seq u_bcd2bin (
        .clk       (clk),
        .reset     (reset),
        .start     (accept),
        .bcd3      (bcd3),
        .bcd2      (bcd2),
        .bcd1      (bcd1),
        .bcd0      (bcd0),
        .done_tick (conv_done),
        .invalid   (conv_invalid),
        .bin       (conv_bin)
    );

    // quo_reg starts as the dividend; its MSB shifts into the remainder
    // while the new quotient bit enters at the LSB
    assign rem_shift = {rem_reg, quo_reg[W-1]};
    assign rem_ge    = (rem_shift >= {1'b0, divisor_reg});
    assign rem_diff  = rem_shift[DW-1:0] - divisor_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            quo_reg     <= '0;
            rem_reg     <= '0;
            divisor_reg <= '0;
            bit_cnt_reg <= '0;
            half_reg    <= '0;
            count_reg   <= '0;
            sq_reg      <= 1'b0;
            ready_reg   <= 1'b1;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        err_reg   <= 1'b0;
                        ready_reg <= 1'b0;
                        state_reg <= S_CONV;
                    end
                end

                S_CONV: begin
                    if (conv_invalid) begin
                        err_reg   <= 1'b1;
                        sq_reg    <= 1'b0;
                        ready_reg <= 1'b1;
                        state_reg <= S_IDLE;
                    end else if (conv_done) begin
                        if (conv_bin == '0) begin
                            err_reg   <= 1'b1;
                            sq_reg    <= 1'b0;
                            ready_reg <= 1'b1;
                            state_reg <= S_IDLE;
                        end else begin
                            divisor_reg <= DW'(conv_bin);
                            rem_reg     <= '0;
                            quo_reg     <= HALF_CLK;
                            bit_cnt_reg <= '0;
                            state_reg   <= S_DIV;
                        end
                    end
                end

                S_DIV: begin
                    rem_reg     <= rem_ge ? rem_diff : rem_shift[DW-1:0];
                    quo_reg     <= {quo_reg[W-2:0], rem_ge};
                    bit_cnt_reg <= bit_cnt_reg + CW'(1);
                    if (bit_cnt_reg == CW'(W - 1)) begin
                        state_reg <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    half_reg  <= quo_reg;
                    count_reg <= '0;
                    sq_reg    <= 1'b1;
                    done_reg  <= 1'b1;
                    ready_reg <= 1'b1;
                    state_reg <= S_RUN;
                end

                S_RUN: begin
                    if (accept) begin
                        sq_reg    <= 1'b0;
                        count_reg <= '0;
                        err_reg   <= 1'b0;
                        ready_reg <= 1'b0;
                        state_reg <= S_CONV;
                    end else if (stop) begin
                        sq_reg    <= 1'b0;
                        count_reg <= '0;
                        state_reg <= S_IDLE;
                    end else if (count_reg == half_reg - W'(1)) begin
                        count_reg <= '0;
                        sq_reg    <= ~sq_reg;
                    end else begin
                        count_reg <= count_reg + W'(1);
                    end
                end

                default: begin
                    sq_reg    <= 1'b0;
                    ready_reg <= 1'b1;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign sq_out    = sq_reg;
    assign ready     = ready_reg;
    assign done_tick = done_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_low_freq_gen.sv
// Directed bench for low_freq_gen: default 50 MHz instance plus a small
// CLK_HZ=1000, W=10 instance sharing clock, reset, digits and stop.
module tb_low_freq_gen;

    logic       clk     = 1'b0;
    logic       reset   = 1'b0;
    logic       start   = 1'b0;
    logic       start_s = 1'b0;
    logic       stop    = 1'b0;
    logic [3:0] bcd3    = 4'd0;
    logic [3:0] bcd2    = 4'd0;
    logic [3:0] bcd1    = 4'd0;
    logic [3:0] bcd0    = 4'd0;

    logic sq_out, ready, done_tick, err;
    logic sq_s, ready_s, done_s, err_s;

    int checks     = 0;
    int failures   = 0;
    int done_cnt   = 0;
    int done_cnt_s = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done_tick) done_cnt++;
        if (done_s) done_cnt_s++;
    end

    low_freq_gen #(.CLK_HZ(50_000_000), .W(26)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .bcd3      (bcd3),
        .bcd2      (bcd2),
        .bcd1      (bcd1),
        .bcd0      (bcd0),
        .sq_out    (sq_out),
        .ready     (ready),
        .done_tick (done_tick),
        .err       (err)
    );

    low_freq_gen #(.CLK_HZ(1000), .W(10)) dut_small (
        .clk       (clk),
        .reset     (reset),
        .start     (start_s),
        .stop      (stop),
        .bcd3      (bcd3),
        .bcd2      (bcd2),
        .bcd1      (bcd1),
        .bcd0      (bcd0),
        .sq_out    (sq_s),
        .ready     (ready_s),
        .done_tick (done_s),
        .err       (err_s)
    );

    task automatic set_digits(input logic [3:0] d3, input logic [3:0] d2,
                              input logic [3:0] d1, input logic [3:0] d0);
        bcd3 = d3;
        bcd2 = d2;
        bcd1 = d1;
        bcd0 = d0;
    endtask

    // returns at the sample point just after the edge that accepts start (edge 0)
    task automatic pulse_start(input logic [3:0] d3, input logic [3:0] d2,
                               input logic [3:0] d1, input logic [3:0] d0);
        @(negedge clk);
        set_digits(d3, d2, d1, d0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int edge_n);
        edge_n = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (done_tick === 1'b1) begin
                edge_n = i;
                break;
            end
        end
    endtask

    task automatic measure(input logic level, input int limit, output int n);
        n = 0;
        while (sq_out === level && n < limit) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (sq_out !== 1'b0) begin failures++; $display("FAIL reset_sq: got %b expected 0", sq_out); end
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", ready); end
        checks++; if (done_tick !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done_tick); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", err); end
        checks++; if (ready_s !== 1'b1) begin failures++; $display("FAIL reset_ready_small: got %b expected 1", ready_s); end
        reset = 1'b0;
        @(negedge clk);
        $display("reset: sq=%b ready=%b done=%b err=%b", sq_out, ready, done_tick, err);
    endtask

    task automatic test_1000hz();
        int e, n_hi, n_lo, base;
        base = done_cnt;
        pulse_start(4'd1, 4'd0, 4'd0, 4'd0);
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL ready_conv: got %b expected 0", ready); end
        // digits are latched; later changes must not matter
        set_digits(4'd9, 4'd9, 4'd9, 4'd9);
        wait_done(40, e);
        checks++; if (e != 31) begin failures++; $display("FAIL done_edge_1000: got %0d expected 31", e); end
        checks++; if (sq_out !== 1'b1) begin failures++; $display("FAIL sq_rise_1000: got %b expected 1", sq_out); end
        measure(1'b1, 30000, n_hi);
        checks++; if (n_hi != 25000) begin failures++; $display("FAIL high_1000: got %0d expected 25000", n_hi); end
        measure(1'b0, 30000, n_lo);
        checks++; if (n_lo != 25000) begin failures++; $display("FAIL low_1000: got %0d expected 25000", n_lo); end
        checks++; if (done_cnt - base != 1) begin failures++; $display("FAIL done_once_1000: got %0d expected 1", done_cnt - base); end
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL ready_run: got %b expected 1", ready); end
        $display("1000 Hz: done edge %0d, high %0d, low %0d", e, n_hi, n_lo);
    endtask

    task automatic test_restart();
        int e, n_hi, base;
        base = done_cnt;
        pulse_start(4'd2, 4'd0, 4'd0, 4'd0);
        checks++; if (sq_out !== 1'b0) begin failures++; $display("FAIL restart_sq: got %b expected 0", sq_out); end
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL restart_ready: got %b expected 0", ready); end
        wait_done(40, e);
        checks++; if (e != 31) begin failures++; $display("FAIL done_edge_2000: got %0d expected 31", e); end
        measure(1'b1, 20000, n_hi);
        checks++; if (n_hi != 12500) begin failures++; $display("FAIL high_2000: got %0d expected 12500", n_hi); end
        checks++; if (done_cnt - base != 1) begin failures++; $display("FAIL done_once_2000: got %0d expected 1", done_cnt - base); end
        $display("restart 2000 Hz: done edge %0d, high %0d", e, n_hi);
    endtask

    task automatic test_bad_digit();
        int e, base;
        base = done_cnt;
        pulse_start(4'd1, 4'd2, 4'hA, 4'd3);
        e = -1;
        for (int i = 1; i <= 4; i++) begin
            if (err === 1'b1 && e < 0) e = i - 1;
            @(negedge clk);
        end
        if (err === 1'b1 && e < 0) e = 4;
        checks++; if (e < 1 || e > 4) begin failures++; $display("FAIL bad_digit_err_edge: got %0d expected 1..4", e); end
        checks++; if (sq_out !== 1'b0) begin failures++; $display("FAIL bad_digit_sq: got %b expected 0", sq_out); end
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL bad_digit_ready: got %b expected 1", ready); end
        repeat (35) @(negedge clk);
        checks++; if (done_cnt - base != 0) begin failures++; $display("FAIL bad_digit_done: got %0d expected 0", done_cnt - base); end
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL bad_digit_sticky: got %b expected 1", err); end
        $display("digit 0xA: err edge %0d, err=%b ready=%b", e, err, ready);
    endtask

    task automatic test_zero();
        int base;
        base = done_cnt;
        pulse_start(4'd0, 4'd0, 4'd0, 4'd0);
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL zero_err_cleared: got %b expected 0", err); end
        repeat (4) @(negedge clk);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL zero_err: got %b expected 1", err); end
        repeat (35) @(negedge clk);
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL zero_ready: got %b expected 1", ready); end
        checks++; if (sq_out !== 1'b0) begin failures++; $display("FAIL zero_sq: got %b expected 0", sq_out); end
        checks++; if (done_cnt - base != 0) begin failures++; $display("FAIL zero_done: got %0d expected 0", done_cnt - base); end
        $display("0000 Hz: err=%b ready=%b sq=%b", err, ready, sq_out);
    endtask

    task automatic test_err_clear();
        int e;
        pulse_start(4'd0, 4'd0, 4'd5, 4'd0);
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL clear_err: got %b expected 0", err); end
        wait_done(40, e);
        checks++; if (e != 31) begin failures++; $display("FAIL done_edge_50: got %0d expected 31", e); end
        repeat (100) @(negedge clk);
        checks++; if (sq_out !== 1'b1) begin failures++; $display("FAIL sq_hold_50: got %b expected 1", sq_out); end
        $display("50 Hz: done edge %0d, err=%b sq=%b", e, err, sq_out);
    endtask

    task automatic test_9999_stop();
        int e, n_hi, n_lo, highs;
        pulse_start(4'd9, 4'd9, 4'd9, 4'd9);
        checks++; if (sq_out !== 1'b0) begin failures++; $display("FAIL abort_sq_9999: got %b expected 0", sq_out); end
        wait_done(40, e);
        checks++; if (e != 31) begin failures++; $display("FAIL done_edge_9999: got %0d expected 31", e); end
        measure(1'b1, 6000, n_hi);
        measure(1'b0, 6000, n_lo);
        checks++; if (n_hi != 2500) begin failures++; $display("FAIL high_9999: got %0d expected 2500", n_hi); end
        checks++; if (n_hi + n_lo != 5000) begin failures++; $display("FAIL period_9999: got %0d expected 5000", n_hi + n_lo); end
        repeat (3) @(negedge clk);
        pulse_stop();
        checks++; if (sq_out !== 1'b0) begin failures++; $display("FAIL stop_sq: got %b expected 0", sq_out); end
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL stop_ready: got %b expected 1", ready); end
        pulse_stop();
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL idle_stop_ready: got %b expected 1", ready); end
        highs = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (sq_out !== 1'b0) highs++;
        end
        checks++; if (highs != 0) begin failures++; $display("FAIL stop_quiet: got %0d high samples expected 0", highs); end
        $display("9999 Hz: done edge %0d, high %0d, low %0d, stopped", e, n_hi, n_lo);
    endtask

    task automatic test_small();
        int e, n_hi, n_lo, base;
        base = done_cnt_s;
        @(negedge clk);
        set_digits(4'd0, 4'd0, 4'd0, 4'd1);
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        checks++; if (ready_s !== 1'b0) begin failures++; $display("FAIL small_ready_conv: got %b expected 0", ready_s); end
        e = -1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (done_s === 1'b1) begin
                e = i;
                break;
            end
        end
        checks++; if (e != 15) begin failures++; $display("FAIL small_done_edge: got %0d expected 15", e); end
        n_hi = 0;
        while (sq_s === 1'b1 && n_hi < 2000) begin n_hi++; @(negedge clk); end
        n_lo = 0;
        while (sq_s === 1'b0 && n_lo < 2000) begin n_lo++; @(negedge clk); end
        checks++; if (n_hi != 500) begin failures++; $display("FAIL small_high: got %0d expected 500", n_hi); end
        checks++; if (n_lo != 500) begin failures++; $display("FAIL small_low: got %0d expected 500", n_lo); end
        checks++; if (err_s !== 1'b0) begin failures++; $display("FAIL small_err: got %b expected 0", err_s); end
        checks++; if (done_cnt_s - base != 1) begin failures++; $display("FAIL small_done_once: got %0d expected 1", done_cnt_s - base); end
        $display("CLK_HZ=1000 W=10, 1 Hz: done edge %0d, high %0d, low %0d", e, n_hi, n_lo);
    endtask

    task automatic test_reset_mid_div();
        int e;
        pulse_start(4'd1, 4'd0, 4'd0, 4'd0);
        repeat (9) @(negedge clk);
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL div_ready: got %b expected 0", ready); end
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        checks++; if (sq_out !== 1'b0) begin failures++; $display("FAIL async_reset_sq: got %b expected 0", sq_out); end
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL async_reset_ready: got %b expected 1", ready); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL async_reset_err: got %b expected 0", err); end
        @(negedge clk);
        reset = 1'b0;
        pulse_start(4'd0, 4'd1, 4'd0, 4'd0);
        e = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done_tick === 1'b1 && e < 0) e = i;
            // a start during conv must be ignored
            if (i == 2) set_digits(4'd9, 4'd9, 4'd9, 4'd9);
            start = (i == 2);
        end
        checks++; if (e != 31) begin failures++; $display("FAIL post_reset_done_edge: got %0d expected 31", e); end
        repeat (3000) @(negedge clk);
        checks++; if (sq_out !== 1'b1) begin failures++; $display("FAIL sq_hold_100: got %b expected 1", sq_out); end
        $display("reset mid-div then 100 Hz: done edge %0d, sq=%b", e, sq_out);
    endtask

    initial begin
        #1 reset = 1'b1;
        test_reset();
        test_1000hz();
        test_restart();
        test_bad_digit();
        test_zero();
        test_err_clear();
        test_9999_stop();
        test_small();
        test_reset_mid_div();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
